// File: rtl/mult_pipe_pkg.sv
// Shared types for the pipelined RV32M multiply unit: issue/FU packets,
// branch-resolution types and the per-stage multiply state.
package mult_pipe_pkg;

    localparam int SYS_XLEN   = 32;
    localparam int NUM_BRANCH = 4;

    typedef logic [NUM_BRANCH-1:0] BR_MASK;

    typedef enum logic [1:0] {
        NOTHING,
        CLEAR,
        SQUASH
    } BR_TASK;

    typedef enum logic [1:0] {
        M_MUL,
        M_MULH,
        M_MULHSU,
        M_MULHU
    } MULT_FUNC;

    typedef struct packed {
        MULT_FUNC   mult_func;
        logic [4:0] dest_reg;
    } DECODED_INST;

    typedef struct packed {
        DECODED_INST decoded_vals;
        BR_MASK      b_mask;
        logic [3:0]  rob_tag;
    } RS_PACKET;

    typedef struct packed {
        logic [SYS_XLEN-1:0] rs1_value;
        logic [SYS_XLEN-1:0] rs2_value;
        RS_PACKET            decoded_vals;
    } ISSUE_PACKET;

    typedef struct packed {
        logic [SYS_XLEN-1:0] result;
        RS_PACKET            decoded_vals;
        logic                pred_correct;
    } FU_PACKET;

    typedef struct packed {
        logic                  valid;
        RS_PACKET              rs;
        logic [2*SYS_XLEN-1:0] prod;
        logic [2*SYS_XLEN-1:0] mcand;
        logic [2*SYS_XLEN-1:0] mplier;
        MULT_FUNC              func;
    } MULT_STAGE_PACKET;

    function automatic logic [2*SYS_XLEN-1:0] extend_operand(
        input logic [SYS_XLEN-1:0] v,
        input logic                is_signed
    );
        return {{SYS_XLEN{is_signed & v[SYS_XLEN-1]}}, v};
    endfunction

endpackage

// File: rtl/mult_stage.sv
// Combinational shift-add slice: folds BITS_PER_STAGE multiplier bits into the
// partial product, then realigns multiplicand and multiplier for the next slice.
module mult_stage
    import mult_pipe_pkg::*;
#(
    parameter int XLEN           = SYS_XLEN,
    parameter int BITS_PER_STAGE = 8,
    parameter bit FINAL          = 1'b0
) (
    input  MULT_STAGE_PACKET stage_in,
    output MULT_STAGE_PACKET stage_out
);
    localparam int W2 = 2 * XLEN;

    logic [W2-1:0] acc;
    logic [W2-1:0] mcand_sh;
    logic [W2-1:0] mplier_sh;

    always_comb begin
        acc = stage_in.prod;
        for (int k = 0; k < BITS_PER_STAGE; k++) begin
            if (stage_in.mplier[k]) begin
                acc = acc + (stage_in.mcand << k);
            end
        end
        mcand_sh  = stage_in.mcand << BITS_PER_STAGE;
        mplier_sh = stage_in.mplier >> BITS_PER_STAGE;
        // Only XLEN multiplier bits are walked; the upper half of a signed
        // multiplier is all ones, worth -(mcand << XLEN) modulo 2^(2*XLEN).
        if (FINAL && mplier_sh[0]) begin
            acc = acc - mcand_sh;
        end
        stage_out        = stage_in;
        stage_out.prod   = acc;
        stage_out.mcand  = mcand_sh;
        stage_out.mplier = mplier_sh;
    end

endmodule

// File: rtl/mult_pipe.sv
// Elastic NUM_STAGES-deep RV32M multiplier with whole-pipe branch mask tracking;
// the last stage register is the output register presented to the CDB.
module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_STAGES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  ISSUE_PACKET is_pack,
    input  logic        rd_in,
    input  logic        stall,
    input  BR_TASK      rem_br_task,
    input  BR_MASK      rem_b_id,
    output logic        ready,
    output FU_PACKET    fu_pack,
    output logic        data_ready
);
    localparam int BITS_PER_STAGE = XLEN / NUM_STAGES;
    localparam int LAST           = NUM_STAGES - 1;

    if (NUM_STAGES < 1 || NUM_STAGES > XLEN || (XLEN % NUM_STAGES) != 0 || XLEN != SYS_XLEN) begin : g_bad_cfg
        $error("mult_pipe: illegal XLEN/NUM_STAGES combination");
    end

    logic [NUM_STAGES-1:0] vld_p;
    logic [NUM_STAGES-1:0] nxt_vld;
    logic [NUM_STAGES-1:0] take;
    MULT_STAGE_PACKET      stg_p     [NUM_STAGES];
    MULT_STAGE_PACKET      nxt_stg   [NUM_STAGES];
    MULT_STAGE_PACKET      stage_in  [NUM_STAGES];
    MULT_STAGE_PACKET      stage_out [NUM_STAGES];

    function automatic logic squash_hit(input BR_TASK t, input BR_MASK m, input BR_MASK id);
        return (t == SQUASH) && ((m & id) != '0);
    endfunction

    // A stage loads when it is empty or its occupant moves on; the chain
    // starts at the output register, which only holds while stalled.
    always_comb begin
        logic t;
        t          = !vld_p[LAST] || !stall;
        take       = '0;
        take[LAST] = t;
        for (int s = NUM_STAGES - 2; s >= 0; s--) begin
            t       = !vld_p[s] || t;
            take[s] = t;
        end
    end

    assign ready = take[0];

    // Operand setup feeds slice 0 straight from the issue packet
    always_comb begin
        stage_in[0].valid  = rd_in;
        stage_in[0].rs     = is_pack.decoded_vals;
        stage_in[0].func   = is_pack.decoded_vals.decoded_vals.mult_func;
        stage_in[0].prod   = '0;
        stage_in[0].mcand  = extend_operand(is_pack.rs1_value,
                                            is_pack.decoded_vals.decoded_vals.mult_func != M_MULHU);
        stage_in[0].mplier = extend_operand(is_pack.rs2_value,
                                            is_pack.decoded_vals.decoded_vals.mult_func == M_MUL ||
                                            is_pack.decoded_vals.decoded_vals.mult_func == M_MULH);
        for (int s = 1; s < NUM_STAGES; s++) begin
            stage_in[s]       = stg_p[s-1];
            stage_in[s].valid = vld_p[s-1];
        end
    end

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        mult_stage #(
            .XLEN           (XLEN),
            .BITS_PER_STAGE (BITS_PER_STAGE),
            .FINAL          (s == LAST)
        ) u_stage (
            .stage_in  (stage_in[s]),
            .stage_out (stage_out[s])
        );
    end

    // Branch resolution hits held and advancing entries on the same edge
    always_comb begin
        for (int s = 0; s < NUM_STAGES; s++) begin
            nxt_stg[s] = take[s] ? stage_out[s] : stg_p[s];
            if (rem_br_task == CLEAR) begin
                nxt_stg[s].rs.b_mask = nxt_stg[s].rs.b_mask & ~rem_b_id;
            end
            nxt_vld[s] = (take[s] ? stage_out[s].valid : vld_p[s]) &&
                         !squash_hit(rem_br_task, nxt_stg[s].rs.b_mask, rem_b_id);
        end
    end

    // Stage registers: valids reset, payload free-running
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p <= '0;
        end else begin
            vld_p <= nxt_vld;
        end
    end

    always_ff @(posedge clock) begin
        for (int s = 0; s < NUM_STAGES; s++) begin
            stg_p[s] <= nxt_stg[s];
        end
    end

    // Output register view
    always_comb begin
        fu_pack    = '0;
        data_ready = vld_p[LAST];
        if (vld_p[LAST]) begin
            fu_pack.result       = (stg_p[LAST].func == M_MUL) ? stg_p[LAST].prod[XLEN-1:0]
                                                               : stg_p[LAST].prod[2*XLEN-1:XLEN];
            fu_pack.decoded_vals = stg_p[LAST].rs;
        end
    end

endmodule

// File: tb/tb_mult_pipe.sv
// Bench for mult_pipe: directed scenarios then random traffic, all checked
// against an in-order queue model using native 64-bit arithmetic.
module tb_mult_pipe;
    import mult_pipe_pkg::*;

    localparam int N  = 4;
    localparam int XW = 32;

    logic        clock = 1'b0;
    logic        reset;
    ISSUE_PACKET is_pack;
    logic        rd_in;
    logic        stall;
    BR_TASK      rem_br_task;
    BR_MASK      rem_b_id;
    logic        ready;
    FU_PACKET    fu_pack;
    logic        data_ready;

    int checks  = 0;
    int errors  = 0;
    int edges   = 0;
    int acc_cnt = 0;
    int quiet   = 0;

    typedef struct {
        logic [31:0] res;
        RS_PACKET    rs;
        int          e;
    } exp_t;

    exp_t q[$];

    mult_pipe #(.XLEN(XW), .NUM_STAGES(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .is_pack     (is_pack),
        .rd_in       (rd_in),
        .stall       (stall),
        .rem_br_task (rem_br_task),
        .rem_b_id    (rem_b_id),
        .ready       (ready),
        .fu_pack     (fu_pack),
        .data_ready  (data_ready)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_mul(input MULT_FUNC f, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            M_MUL:    begin p = sa * sb; return p[31:0]; end
            M_MULH:   begin p = sa * sb; return p[63:32]; end
            M_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            default:  begin p = ua * ub; return p[63:32]; end
        endcase
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input MULT_FUNC f, input logic [31:0] a, input logic [31:0] b, input BR_MASK m);
        rd_in                                  = 1'b1;
        is_pack.rs1_value                      = a;
        is_pack.rs2_value                      = b;
        is_pack.decoded_vals.decoded_vals.mult_func = f;
        is_pack.decoded_vals.decoded_vals.dest_reg  = 5'($urandom);
        is_pack.decoded_vals.b_mask            = m;
        is_pack.decoded_vals.rob_tag           = 4'($urandom);
    endtask

    // One clock: check outputs against the model, then advance model and DUT.
    task automatic step();
        logic     exp_dr;
        logic     exp_rdy;
        logic     acc;
        logic     cons;
        FU_PACKET exp_fu;
        exp_t     n;
        exp_t     keep[$];
        #1;
        exp_rdy = (q.size() < N) || !stall;
        exp_dr  = (q.size() > 0) && (edges - q[0].e >= N - 1);
        exp_fu  = '0;
        if (exp_dr) begin
            exp_fu.result       = q[0].res;
            exp_fu.decoded_vals = q[0].rs;
        end
        check("ready", 64'(ready), 64'(exp_rdy));
        check("data_ready", 64'(data_ready), 64'(exp_dr));
        check("fu_pack", 64'(fu_pack), 64'(exp_fu));
        acc  = rd_in && exp_rdy;
        cons = exp_dr && !stall;
        if (rd_in && ready) acc_cnt++;
        n.res = ref_mul(is_pack.decoded_vals.decoded_vals.mult_func, is_pack.rs1_value, is_pack.rs2_value);
        n.rs  = is_pack.decoded_vals;
        @(posedge clock);
        edges++;
        n.e = edges;
        if (cons) void'(q.pop_front());
        if (acc) q.push_back(n);
        if (rem_br_task == CLEAR) begin
            foreach (q[i]) q[i].rs.b_mask = q[i].rs.b_mask & ~rem_b_id;
        end else if (rem_br_task == SQUASH) begin
            keep = {};
            foreach (q[i]) if ((q[i].rs.b_mask & rem_b_id) == '0) keep.push_back(q[i]);
            q = keep;
        end
        #1;
    endtask

    task automatic basic(input MULT_FUNC f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input string tag);
        drive(f, a, b, '0);
        step();
        rd_in = 1'b0;
        repeat (N - 1) step();
        #1;
        check({tag, "_ready"}, 64'(data_ready), 64'(1));
        check({tag, "_res"}, 64'(fu_pack.result), 64'(want));
        step();
    endtask

    initial begin
        reset       = 1'b1;
        rd_in       = 1'b0;
        stall       = 1'b0;
        is_pack     = '0;
        rem_br_task = NOTHING;
        rem_b_id    = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_data_ready", 64'(data_ready), 64'(0));
        check("rst_fu_pack", 64'(fu_pack), 64'(0));
        check("rst_ready", 64'(ready), 64'(1));
        reset = 1'b0;
        repeat (2) step();

        basic(M_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
        basic(M_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
        basic(M_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        basic(M_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");

        for (int i = 1; i <= 8; i++) begin
            drive(M_MUL, 32'(i), 32'(i + 1), '0);
            step();
        end
        rd_in = 1'b0;
        repeat (N + 2) step();

        drive(M_MUL, 32'd100, 32'd3, '0);
        step();
        rd_in = 1'b0;
        repeat (N - 1) step();
        stall   = 1'b1;
        acc_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            drive(M_MUL, 32'(k + 10), 32'(k + 3), '0);
            step();
        end
        rd_in = 1'b0;
        #1;
        check("fill_accepts", 64'(acc_cnt), 64'(3));
        check("fill_ready", 64'(ready), 64'(0));
        check("fill_hold", 64'(fu_pack.result), 64'(300));
        step();
        stall = 1'b0;
        repeat (N + 2) step();

        drive(M_MUL, 32'd5, 32'd6, 4'b0001);
        step();
        drive(M_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 4'b0010);
        step();
        drive(M_MULH, 32'hFFFF_0000, 32'h0001_FFFF, 4'b0000);
        step();
        rd_in       = 1'b0;
        rem_br_task = SQUASH;
        rem_b_id    = 4'b0010;
        step();
        rem_br_task = NOTHING;
        rem_b_id    = '0;
        repeat (N + 2) step();

        drive(M_MULHU, 32'h1234, 32'h5678, 4'b0011);
        step();
        rd_in = 1'b0;
        repeat (N - 1) step();
        stall = 1'b1;
        step();
        rem_br_task = CLEAR;
        rem_b_id    = 4'b0001;
        step();
        rem_br_task = NOTHING;
        rem_b_id    = '0;
        #1;
        check("clear_mask", 64'(fu_pack.decoded_vals.b_mask), 64'(4'b0010));
        check("clear_ready", 64'(data_ready), 64'(1));
        step();
        stall = 1'b0;
        repeat (N + 2) step();

        for (int k = 0; k < 3; k++) begin
            drive(M_MUL, 32'(k + 21), 32'(k + 2), '0);
            step();
        end
        rd_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("arst_data_ready", 64'(data_ready), 64'(0));
        check("arst_fu_pack", 64'(fu_pack), 64'(0));
        reset = 1'b0;
        q.delete();
        repeat (N + 2) step();

        quiet = N;
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) < 7) begin
                drive(MULT_FUNC'($urandom_range(0, 3)), rand_op(), rand_op(), BR_MASK'($urandom_range(0, 15)));
            end else begin
                rd_in = 1'b0;
            end
            rem_br_task = NOTHING;
            rem_b_id    = '0;
            if (!stall && quiet >= N && $urandom_range(0, 7) == 0) begin
                rem_br_task = ($urandom_range(0, 1) == 0) ? CLEAR : SQUASH;
                rem_b_id    = BR_MASK'(1 << $urandom_range(0, 3));
            end
            step();
            quiet = stall ? 0 : quiet + 1;
        end
        rd_in       = 1'b0;
        stall       = 1'b0;
        rem_br_task = NOTHING;
        rem_b_id    = '0;
        repeat (N + 2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
